// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code decoder.
//   state_e    : acquisition FSM states
//   CODE_TABLE : legal 4-bit Johnson codes, indexed by step number 0..7
//   succ()     : successor step index, wrapping 7 -> 0
package johnson_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] CODE_TABLE [8] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0111,
    4'b1111, 4'b1110, 4'b1100, 4'b1000
  };

  function automatic logic [2:0] succ(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample/result bundle of the Johnson decoder.
//   Count_in/Valid_in                 : sampled Johnson code and its qualifier
//   Index_out/Onehot_out/Out_valid    : decoded step of the last legal sample
//   Code_err/Seq_err                  : error pulses
//   Locked/Err_count                  : lock level and saturating error count
// master = sample source side, slave = decoder side.
interface johnson_decoder_if;
  logic [3:0] Count_in;
  logic       Valid_in;
  logic [2:0] Index_out;
  logic [7:0] Onehot_out;
  logic       Out_valid;
  logic       Code_err;
  logic       Seq_err;
  logic       Locked;
  logic [7:0] Err_count;

  modport master (
    output Count_in, Valid_in,
    input  Index_out, Onehot_out, Out_valid, Code_err, Seq_err, Locked, Err_count
  );

  modport slave (
    input  Count_in, Valid_in,
    output Index_out, Onehot_out, Out_valid, Code_err, Seq_err, Locked, Err_count
  );
endinterface

// File: rtl/johnson_code_lut.sv
// Combinational Johnson code lookup.
//   code_i  : 4-bit sampled code
//   index_o : step index 0..7 (0 when illegal)
//   legal_o : code is one of the 8 legal Johnson codes
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [2:0] index_o,
  output logic       legal_o
);

  always_comb begin
    index_o = '0;
    legal_o = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (code_i == CODE_TABLE[k]) begin
        index_o = k[2:0];
        legal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder with sequence lock tracking.
//   Clock   : rising-edge clock
//   Reset_n : synchronous active-low reset
//   bus     : slave side of johnson_decoder_if (samples in, decoded/status out)
// LOCK_CNT consecutive in-sequence samples (first included) declare lock.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic              Clock,
  input  logic              Reset_n,
  johnson_decoder_if.slave  bus
);

  localparam logic [4:0] LOCK_CNT_W = 5'(LOCK_CNT);

  state_e     state_q, state_d;
  logic [3:0] match_q, match_d;
  logic [2:0] exp_q, exp_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] onehot_q, onehot_d;
  logic       ovalid_q, ovalid_d;
  logic       cerr_q, cerr_d;
  logic       serr_q, serr_d;
  logic       locked_q, locked_d;
  logic [7:0] errcnt_q, errcnt_d;

  logic [2:0] lut_idx;
  logic       lut_legal;
  logic [4:0] match_inc;
  logic       hit;

  johnson_code_lut u_lut (
    .code_i  (bus.Count_in),
    .index_o (lut_idx),
    .legal_o (lut_legal)
  );

  assign match_inc = {1'b0, match_q} + 5'd1;
  assign hit       = (lut_idx == exp_q);

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ovalid_d = 1'b0;
    cerr_d   = 1'b0;
    serr_d   = 1'b0;
    errcnt_d = errcnt_q;

    if (bus.Valid_in) begin
      if (lut_legal) begin
        idx_d    = lut_idx;
        onehot_d = 8'd1 << lut_idx;
        ovalid_d = 1'b1;
        unique case (state_q)
          ST_HUNT: begin
            match_d = 4'd1;
            exp_d   = succ(lut_idx);
            state_d = (LOCK_CNT_W == 5'd1) ? ST_LOCKED : ST_ACQ;
          end
          ST_ACQ: begin
            exp_d = succ(lut_idx);
            if (hit) begin
              match_d = match_inc[3:0];
              if (match_inc >= LOCK_CNT_W) state_d = ST_LOCKED;
            end else begin
              // Legal mismatch while acquiring just restarts from this sample.
              match_d = 4'd1;
            end
          end
          ST_LOCKED: begin
            exp_d = succ(lut_idx);
            if (!hit) begin
              serr_d  = 1'b1;
              match_d = 4'd1;
              state_d = ST_ACQ;
            end
          end
          default: state_d = ST_HUNT;
        endcase
      end else begin
        cerr_d  = 1'b1;
        match_d = '0;
        state_d = ST_HUNT;
      end

      if ((cerr_d || serr_d) && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= ST_HUNT;
      match_q  <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      ovalid_q <= 1'b0;
      cerr_q   <= 1'b0;
      serr_q   <= 1'b0;
      locked_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ovalid_q <= ovalid_d;
      cerr_q   <= cerr_d;
      serr_q   <= serr_d;
      locked_q <= locked_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.Index_out  = idx_q;
  assign bus.Onehot_out = onehot_q;
  assign bus.Out_valid  = ovalid_q;
  assign bus.Code_err   = cerr_q;
  assign bus.Seq_err    = serr_q;
  assign bus.Locked     = locked_q;
  assign bus.Err_count  = errcnt_q;

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive in-sequence samples (first included) needed to declare lock; legal range 1..15.
REQ-002 Clock  input  1  rising-edge clock; only clock in block.
REQ-003 Reset_n  input  1  reset is synchronous and active-low.
REQ-004 Count_in  input  4  Johnson code sampled from a 4-bit Johnson counter.
REQ-005 Valid_in  input  1  Count_in is a new counter step this cycle; when low, Count_in is ignored.
REQ-006 Index_out  output  3  decoded step index 0..7 of last legal sample.
REQ-007 Onehot_out  output  8  one-hot of Index_out (bit i set for index i).
REQ-008 Out_valid  output  1  one-cycle pulse: Index_out/Onehot_out updated.
REQ-009 Code_err  output  1  one-cycle pulse: sample was an illegal code.
REQ-010 Seq_err  output  1  one-cycle pulse: legal code but not expected successor while locked.
REQ-011 Locked  output  1  level: FSM in LOCKED.
REQ-012 Err_count  output  8  saturating count of Code_err plus Seq_err pulses.

Function
REQ-013 Code table SHALL be 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7; the other 8 codes are illegal.
REQ-014 Successor of index i SHALL be (i+1) mod 8; index 7 (1000) wraps to index 0 (0000).
REQ-015 All outputs SHALL be registered; every flag/output responds exactly 1 cycle after the Valid_in=1 sample.
REQ-016 Cycles with Valid_in=0 SHALL change no state, count, or output, and all pulses SHALL be 0.
REQ-017 Legal valid sample: Index_out/Onehot_out load its index, Out_valid pulses, in every state.
REQ-018 Illegal valid sample: Index_out/Onehot_out hold, Out_valid=0, Code_err pulses, in every state.
REQ-019 FSM states: HUNT, ACQ, LOCKED; 4-bit match counter; expected index register.
REQ-020 HUNT: legal -> ACQ with match=1, expected=successor (if LOCK_CNT=1, go directly to LOCKED); illegal -> stay HUNT.
REQ-021 ACQ: sample == expected -> match+1, expected advances; LOCKED when match reaches LOCK_CNT.
REQ-022 ACQ: legal mismatch -> restart ACQ, match=1, expected from this sample, no Seq_err; illegal -> HUNT.
REQ-023 LOCKED: sample == expected -> stay, expected advances.
REQ-024 LOCKED: legal mismatch -> Seq_err pulse, ACQ with match=1; illegal -> Code_err pulse, HUNT.
REQ-025 Locked SHALL go high the cycle after the LOCK_CNT-th matching sample and low the cycle after the breaking sample.
REQ-026 Err_count SHALL increment by 1 per Code_err or Seq_err pulse (never both in one cycle) and saturate at 255.
REQ-027 A repeated code (hold) while Valid_in=1 SHALL count as a mismatch.

Reset
REQ-028 While Reset_n=0 at a rising edge: state=HUNT, match=0, expected=0, Index_out=0, Onehot_out=8'h00, Out_valid/Code_err/Seq_err/Locked=0, Err_count=0.
REQ-029 Reset SHALL override any in-progress sample, including in LOCKED; the first sample after release is treated as from HUNT.

Structure
REQ-030 Package johnson_pkg SHALL hold the FSM state enum, the 8-entry legal code table, and the successor constant/function.
REQ-031 Combinational sub-module johnson_code_lut (Count_in -> index, legal) SHALL implement REQ-013; FSM, counters, and registers stay in johnson_decoder.

Verification
REQ-032 Reset, then 10 valid steps 0000,0001,0011,0111,1111,1110,1100,1000,0000,0001 -> Index_out 0..7,0,1; Locked=1 from cycle after 3rd sample; Err_count=0.
REQ-033 Locked at index 2, apply 1111 (skips 0111) -> Seq_err pulse, Locked=0, Index_out=4, Err_count=1; 2 more in-sequence samples -> Locked=1.
REQ-034 Locked, apply 0101 -> Code_err pulse, Index_out holds, state HUNT, Locked=0, Err_count+1.
REQ-035 Valid_in=0 for 5 cycles with random Count_in mid-sequence -> no output change; resume with expected code -> lock kept.
REQ-036 300 illegal samples (1010) -> Err_count stops at 255, Code_err pulses each sample.
REQ-037 Reset_n=0 for one edge while locked -> all outputs per REQ-028 on next cycle; sequence resumes from HUNT.
